native_mem_responder: RTL and testbench

//  Target-side responder for the picorv32 native memory bus: the end that answers mem_valid with mem_ready.

---
 rtl/native_mem_responder.sv | 129 ++++++++++++
 tb/tb_native_mem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/native_mem_responder.sv
// Target-side picorv32 native-bus RAM: byte-lane writes, WAIT_STATES cycles of wait before mem_ready.
// Latency 1+WAIT_STATES cycles; a dropped mem_valid during WAIT aborts. NATIVE_MEM_RESP_ERR_EN enables bus_err.
module native_mem_responder #(
  parameter int    ADDR_WIDTH  = 14,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        bus_err
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] live_word, word_q, cur_word;
  logic        live_rd, rd_q, cur_rd;
  logic        live_wr, wr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rd_value;

  assign live_word = mem_addr[ADDR_WIDTH+1:2];
  // Instruction fetches never write, whatever the strobes say.
  assign live_rd   = (mem_wstrb == 4'b0000) || mem_instr;

`ifdef NATIVE_MEM_RESP_ERR_EN
  logic live_oor, oor_q, cur_oor;
  logic unused_addr;
  assign live_oor    = |(mem_addr >> (ADDR_WIDTH + 2));
  assign unused_addr = ^mem_addr[1:0];
  assign live_wr     = !live_rd && !live_oor;
  assign cur_oor     = (state_q == S_IDLE) ? live_oor : oor_q;
  assign rd_value    = cur_oor ? 32'hDEAD_BEEF : mem[cur_word];
  assign bus_err     = (state_q == S_RESP) && oor_q;
`else
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
  assign live_wr     = !live_rd;
  assign rd_value    = mem[cur_word];
  assign bus_err     = 1'b0;
`endif

  // With zero wait states the read happens straight out of IDLE, so use the live request.
  assign cur_word = (state_q == S_IDLE) ? live_word : word_q;
  assign cur_rd   = (state_q == S_IDLE) ? live_rd   : rd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          cnt_d   = WS;
          state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!mem_valid) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      mem_rdata <= 32'd0;
      word_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
`ifdef NATIVE_MEM_RESP_ERR_EN
      oor_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && mem_valid) begin
        word_q  <= live_word;
        rd_q    <= live_rd;
        wr_q    <= live_wr;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
`ifdef NATIVE_MEM_RESP_ERR_EN
        oor_q   <= live_oor;
`endif
      end
      if (state_d == S_RESP && cur_rd) mem_rdata <= rd_value;
    end
  end

  // Commit happens on the edge that ends RESP; an async reset earlier leaves state IDLE.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[word_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_ready = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_native_mem_responder.sv
// Bench for native_mem_responder: vector table, corner sequences and a randomized byte-lane model.
module tb_native_mem_responder;

`ifdef NATIVE_MEM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, busy, bus_err;
  logic [31:0] mem_rdata;

  logic        z_valid = 1'b0, z_instr = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [3:0]  z_wstrb = '0;
  logic        z_ready, z_busy, z_err;
  logic [31:0] z_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  native_mem_responder #(.ADDR_WIDTH(14), .WAIT_STATES(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .bus_err(bus_err)
  );

  native_mem_responder #(.ADDR_WIDTH(14), .WAIT_STATES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .mem_valid(z_valid), .mem_instr(z_instr),
    .mem_addr(z_addr), .mem_wdata(z_wdata), .mem_wstrb(z_wstrb),
    .mem_ready(z_ready), .mem_rdata(z_rdata), .busy(z_busy), .bus_err(z_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle, returns in the next IDLE cycle.
  task automatic do_txn(input string name, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ins,
                        input logic [31:0] exp_rd, input logic exp_er);
    int n;
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) check({name, "_busy"}, 32'(busy), 32'd1);
      if (mem_ready) begin
        n = k;
        break;
      end
    end
    check({name, "_lat"}, n, LAT);
    check({name, "_rdata"}, mem_rdata, exp_rd);
    check({name, "_err"}, 32'(bus_err), 32'(exp_er));
    mem_valid = 1'b0; mem_wstrb = 4'd0; mem_instr = 1'b0;
    tick();
    check({name, "_pulse"}, 32'(mem_ready), 32'd0);
  endtask

  task automatic z_write(input logic [31:0] a, input logic [31:0] d);
    z_valid = 1'b1; z_addr = a; z_wdata = d; z_wstrb = 4'hF;
    tick();
    check("z_wr_lat", 32'(z_ready), 32'd1);
    z_valid = 1'b0; z_wstrb = 4'd0;
    tick();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] ref_mem [16];
  logic [31:0] last_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h100, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{32'h100, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[2] = '{32'h100, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h1234_5678, 1'b0};
    vecs[3] = '{32'h100, 32'h0, 4'h0, 1'b0, 32'h12BB_56DD, 1'b0};
    vecs[4] = '{32'h100, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h12BB_56DD, 1'b0};
    vecs[5] = '{32'h102, 32'h0, 4'h0, 1'b0, 32'h12BB_56DD, 1'b0};
    vecs[6] = '{32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h12BB_56DD, 1'b0};
    vecs[7] = '{32'h0001_0000, 32'h0, 4'h0, 1'b0, ERR ? 32'hDEAD_BEEF : 32'hCAFE_F00D, ERR};
    vecs[8] = '{32'h0001_0000, 32'h0102_0304, 4'hF, 1'b0, ERR ? 32'hDEAD_BEEF : 32'hCAFE_F00D, ERR};
    vecs[9] = '{32'h0, 32'h0, 4'h0, 1'b0, ERR ? 32'hCAFE_F00D : 32'h0102_0304, 1'b0};

    // Reset held with a request pending.
    mem_valid = 1'b1; z_valid = 1'b1;
    repeat (3) tick();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_z_ready", 32'(z_ready), 32'd0);
    mem_valid = 1'b0; z_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].instr, vecs[i].exp_rdata, vecs[i].exp_err);

    // Zero wait states: back-to-back reads.
    z_write(32'h0, 32'h11);
    z_write(32'h4, 32'h22);
    z_valid = 1'b1; z_addr = 32'h0; z_wstrb = 4'd0;
    tick();
    check("z_b2b_rdy0", 32'(z_ready), 32'd1);
    check("z_b2b_d0", z_rdata, 32'h11);
    z_addr = 32'h4;
    tick();
    check("z_b2b_gap", 32'(z_ready), 32'd0);
    tick();
    check("z_b2b_rdy1", 32'(z_ready), 32'd1);
    check("z_b2b_d1", z_rdata, 32'h22);
    z_valid = 1'b0;
    tick();
    check("z_b2b_idle", 32'(z_ready), 32'd0);

    // Abort: mem_valid dropped during WAIT.
    do_txn("ab_pre", 32'h200, 32'h5555_AAAA, 4'hF, 1'b0, ERR ? 32'hCAFE_F00D : 32'h0102_0304, 1'b0);
    begin
      int seen;
      seen = 0;
      mem_valid = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h0BAD_0BAD; mem_wstrb = 4'hF;
      tick();
      check("ab_busy", 32'(busy), 32'd1);
      mem_valid = 1'b0; mem_wstrb = 4'd0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (mem_ready) seen++;
      end
      check("ab_noready", seen, 0);
      check("ab_idle", 32'(busy), 32'd0);
    end
    do_txn("ab_rd", 32'h200, 32'h0, 4'h0, 1'b0, 32'h5555_AAAA, 1'b0);

    // Reset during RESP of a write: nothing committed.
    do_txn("rr_pre", 32'h300, 32'h7777_1111, 4'hF, 1'b0, 32'h5555_AAAA, 1'b0);
    begin
      int got;
      got = 0;
      mem_valid = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h9999_2222; mem_wstrb = 4'hF;
      for (int k = 0; k < 20; k++) begin
        tick();
        if (mem_ready) begin
          got = 1;
          break;
        end
      end
      check("rr_reach", got, 1);
      rst_n = 1'b0;
      #1;
      check("rr_ready", 32'(mem_ready), 32'd0);
      check("rr_busy", 32'(busy), 32'd0);
      check("rr_rdata", mem_rdata, 32'd0);
      mem_valid = 1'b0; mem_wstrb = 4'd0;
      tick();
      rst_n = 1'b1;
      tick();
    end
    do_txn("rr_rd", 32'h300, 32'h0, 4'h0, 1'b0, 32'h7777_1111, 1'b0);
    last_rd = 32'h7777_1111;

    // Randomized traffic over a 16-word window against a byte-lane model.
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      do_txn("fill", 32'h1000 + 32'(i) * 4, ref_mem[i], 4'hF, 1'b0, last_rd, 1'b0);
    end
    for (int t = 0; t < 60; t++) begin
      int unsigned idx, hi;
      logic [31:0] a, d, exp;
      logic [3:0]  s;
      logic        ins, oor, is_rd;
      idx = $urandom_range(0, 15);
      hi  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16'hFFFF) : 0;
      a   = (32'(hi) << 16) | (32'h1000 + 32'(idx) * 4) | 32'($urandom_range(0, 3));
      d   = $urandom;
      s   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'd0;
      ins = ($urandom_range(0, 7) == 0);
      oor = (hi != 0);
      is_rd = (s == 4'd0) || ins;
      if (is_rd) begin
        exp = (ERR && oor) ? 32'hDEAD_BEEF : ref_mem[idx];
        last_rd = exp;
      end else begin
        exp = last_rd;
        if (!(ERR && oor))
          for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end
      do_txn($sformatf("rnd%0d", t), a, d, s, ins, exp, ERR && oor);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
